// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd7
    } imm_type_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_BRANCH = 2'd2;

    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic alui;
        logic alur;
        logic lui;
        logic jal;
        logic jalr;
    } op_class_t;

    function automatic logic [1:0] wb_sel_of(op_class_t c);
        if (c.load)              return WB_MEM;
        else if (c.jal || c.jalr) return WB_PC4;
        else if (c.lui)          return WB_IMM;
        else                     return WB_ALU;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_decode.sv
// Combinational opcode classifier: class flags, immediate format, illegal flag.
module opcode_decode
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output imm_type_t  imm_type,
    output logic       illegal
);

    always_comb begin
        op_class = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD:   begin op_class.load   = 1'b1; imm_type = IMM_I; end
            OP_STORE:  begin op_class.store  = 1'b1; imm_type = IMM_S; end
            OP_BRANCH: begin op_class.branch = 1'b1; imm_type = IMM_B; end
            OP_ALUI:   begin op_class.alui   = 1'b1; imm_type = IMM_I; end
            OP_ALUR:   begin op_class.alur   = 1'b1; imm_type = IMM_NONE; end
            OP_LUI:    begin op_class.lui    = 1'b1; imm_type = IMM_U; end
            OP_JAL:    begin op_class.jal    = 1'b1; imm_type = IMM_J; end
            OP_JALR:   begin op_class.jalr   = 1'b1; imm_type = IMM_I; end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core, with memory timeout and
// retired-instruction counter.
//
// state  | meaning
// FETCH  | request instruction word at PC, load IR and PC+4 on mem_ready
// DECODE | classify opcode, present immediate format, trap on illegal
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data access at ALU address; stores retire on mem_ready
// WB     | register file write, retire
// HALT   | trap taken, everything idle until reset
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_code,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic [1:0]       alu_ctl,
    output imm_type_t        imm_type,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    tmo_q;
    logic             tmo_tc;
    logic [CNT_W-1:0] instret_q;
    logic             trap_q;
    logic             trap_set;
    logic             retire;

    op_class_t        cls;
    imm_type_t        dec_imm;
    logic             illegal;
    logic             unused_inst_bits;

    assign unused_inst_bits = ^inst_code[31:7];

    opcode_decode u_dec (
        .opcode   (inst_code[6:0]),
        .op_class (cls),
        .imm_type (dec_imm),
        .illegal  (illegal)
    );

    // Down-counter reloaded on entry to a waiting state; zero is the last allowed wait cycle.
    assign tmo_tc = (tmo_q == '0);

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        alu_src_b    = 1'b0;
        alu_ctl      = ALU_ADD;
        imm_type     = IMM_NONE;
        trap_set     = 1'b0;
        retire       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmo_tc) begin
                    trap_set = 1'b1;
                    state_d  = ST_HALT;
                end
            end
            ST_DECODE: begin
                imm_type = dec_imm;
                if (illegal) begin
                    trap_set = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                imm_type  = dec_imm;
                alu_src_b = !(cls.alur || cls.branch);
                if (cls.branch)                alu_ctl = ALU_BRANCH;
                else if (cls.alur || cls.alui) alu_ctl = ALU_FUNCT;
                if (cls.branch) begin
                    pc_we   = branch_taken;
                    pc_sel  = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls.jal || cls.jalr) begin
                    pc_we   = 1'b1;
                    pc_sel  = 1'b1;
                    state_d = ST_WB;
                end else if (cls.load || cls.store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                imm_type     = dec_imm;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = cls.store;
                if (mem_ready) begin
                    if (cls.store) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_tc) begin
                    trap_set = 1'b1;
                    state_d  = ST_HALT;
                end
            end
            ST_WB: begin
                imm_type = dec_imm;
                reg_we   = 1'b1;
                wb_sel   = wb_sel_of(cls);
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            tmo_q     <= TMO_LOAD;
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)))
                tmo_q <= TMO_LOAD;
            else if (mem_req && !mem_ready && !tmo_tc)
                tmo_q <= tmo_q - TW'(1);
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
            if (trap_set)
                trap_q <= 1'b1;
        end
    end

    assign instret = instret_q;
    assign trap    = trap_q;
    assign busy    = (state_q != ST_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction cycle script derived from the control rules,
// compared against the DUT every cycle.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 6;

    localparam int C_LOAD = 0, C_STORE = 1, C_BRANCH = 2, C_ALUI = 3, C_ALUR = 4,
                   C_LUI = 5, C_JAL = 6, C_JALR = 7, C_ILL = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      inst_code = '0;
    logic             mem_ready = 1'b0;
    logic             branch_taken = 1'b0;
    logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we;
    logic [1:0]       wb_sel;
    logic             alu_src_b;
    logic [1:0]       alu_ctl;
    logic [2:0]       imm_type;
    logic [CNT_W-1:0] instret;
    logic             trap, busy;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .inst_code(inst_code), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
        .imm_type(imm_type), .instret(instret), .trap(trap), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [31:0]      inst;
        logic             rdy, tkn;
        logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we;
        logic [1:0]       wb_sel;
        logic             alu_src_b;
        logic [1:0]       alu_ctl;
        logic [2:0]       imm_type;
        logic [CNT_W-1:0] instret;
        logic             trap, busy;
        logic             chk_alu, chk_imm;
    } cyc_t;

    cyc_t             q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_trap = 1'b0;
    logic [31:0]      cur_inst = '0;
    int               abort_at, icyc;
    bit               aborted;
    int               total = 0, bad = 0, cyc_no = 0;

    function automatic int cls_of(logic [6:0] op);
        case (op)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b0010011: return C_ALUI;
            7'b0110011: return C_ALUR;
            7'b0110111: return C_LUI;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(int c);
        case (c)
            C_STORE:  return 3'd1;
            C_BRANCH: return 3'd2;
            C_LUI:    return 3'd3;
            C_JAL:    return 3'd4;
            C_ALUR:   return 3'd7;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic cyc_t base();
        cyc_t r;
        r.rst = 0; r.inst = cur_inst; r.rdy = 0; r.tkn = 1'($urandom_range(0, 1));
        r.mem_req = 0; r.mem_we = 0; r.mem_addr_sel = 0; r.ir_we = 0; r.pc_we = 0;
        r.pc_sel = 0; r.reg_we = 0; r.wb_sel = 0; r.alu_src_b = 0; r.alu_ctl = 0;
        r.imm_type = 0; r.instret = m_cnt; r.trap = m_trap; r.busy = 1;
        r.chk_alu = 0; r.chk_imm = 0;
        return r;
    endfunction

    task automatic push(input cyc_t r);
        if (aborted) return;
        if (icyc == abort_at) begin
            r.rst = 1'b1;
            aborted = 1;
        end
        q.push_back(r);
        icyc++;
        if (aborted) begin
            m_cnt = '0;
            m_trap = 1'b0;
        end
    endtask

    task automatic retire();
        if (!aborted) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic set_trap(output bit halted);
        halted = 0;
        if (!aborted) begin
            m_trap = 1'b1;
            halted = 1;
        end
    endtask

    // One instruction: fw/mw are wait cycles before mem_ready (>=TIMEOUT means never), ab = cycle index carrying reset.
    task automatic gen_instr(input logic [31:0] inst, input int fw, input int mw, input bit tk,
                             input int ab, output bit halted);
        cyc_t r;
        int c;
        cur_inst = inst; abort_at = ab; icyc = 0; aborted = 0; halted = 0;
        c = cls_of(inst[6:0]);
        for (int i = 0; i < fw && i < TIMEOUT; i++) begin
            r = base(); r.mem_req = 1; push(r);
        end
        if (fw >= TIMEOUT) begin set_trap(halted); return; end
        r = base(); r.rdy = 1; r.mem_req = 1; r.ir_we = 1; r.pc_we = 1; push(r);
        r = base(); r.rdy = 1'($urandom_range(0, 1));
        r.chk_imm = (c != C_ILL); r.imm_type = imm_of(c); push(r);
        if (c == C_ILL) begin set_trap(halted); return; end
        r = base(); r.rdy = 1'($urandom_range(0, 1)); r.chk_alu = 1;
        r.alu_src_b = !(c == C_ALUR || c == C_BRANCH);
        r.alu_ctl = (c == C_BRANCH) ? 2'd2 : (c == C_ALUR || c == C_ALUI) ? 2'd1 : 2'd0;
        if (c == C_BRANCH) begin
            r.tkn = tk; r.pc_we = tk; r.pc_sel = 1; push(r); retire(); return;
        end
        if (c == C_JAL || c == C_JALR) begin r.pc_we = 1; r.pc_sel = 1; end
        push(r);
        if (c == C_LOAD || c == C_STORE) begin
            for (int i = 0; i < mw && i < TIMEOUT; i++) begin
                r = base(); r.mem_req = 1; r.mem_addr_sel = 1; r.mem_we = (c == C_STORE); push(r);
            end
            if (mw >= TIMEOUT) begin set_trap(halted); return; end
            r = base(); r.rdy = 1; r.mem_req = 1; r.mem_addr_sel = 1; r.mem_we = (c == C_STORE);
            push(r);
            if (c == C_STORE) begin retire(); return; end
        end
        r = base(); r.rdy = 1'($urandom_range(0, 1)); r.reg_we = 1;
        r.wb_sel = (c == C_LOAD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : (c == C_LUI) ? 2'd3 : 2'd0;
        push(r);
        retire();
    endtask

    task automatic gen_halt(input int n, input bit rst_last);
        cyc_t r;
        for (int i = 0; i < n; i++) begin
            r = base(); r.busy = 0; r.rdy = 1'($urandom_range(0, 1));
            if (rst_last && i == n - 1) r.rst = 1;
            q.push_back(r);
        end
        if (rst_last) begin m_cnt = '0; m_trap = 1'b0; end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_no, act, exp);
        end
    endtask

    task automatic compare(input cyc_t r);
        chk("mem_req", 32'(mem_req), 32'(r.mem_req));
        chk("mem_we", 32'(mem_we), 32'(r.mem_we));
        chk("ir_we", 32'(ir_we), 32'(r.ir_we));
        chk("pc_we", 32'(pc_we), 32'(r.pc_we));
        chk("reg_we", 32'(reg_we), 32'(r.reg_we));
        chk("busy", 32'(busy), 32'(r.busy));
        chk("trap", 32'(trap), 32'(r.trap));
        chk("instret", 32'(instret), 32'(r.instret));
        if (r.mem_req) chk("mem_addr_sel", 32'(mem_addr_sel), 32'(r.mem_addr_sel));
        if (r.pc_we)   chk("pc_sel", 32'(pc_sel), 32'(r.pc_sel));
        if (r.reg_we)  chk("wb_sel", 32'(wb_sel), 32'(r.wb_sel));
        if (r.chk_alu) begin
            chk("alu_src_b", 32'(alu_src_b), 32'(r.alu_src_b));
            chk("alu_ctl", 32'(alu_ctl), 32'(r.alu_ctl));
        end
        if (r.chk_imm) chk("imm_type", 32'(imm_type), 32'(r.imm_type));
    endtask

    task automatic run_queue();
        cyc_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(posedge clk);
            #1;
            reset = r.rst; inst_code = r.inst; mem_ready = r.rdy; branch_taken = r.tkn;
            @(negedge clk);
            compare(r);
            cyc_no++;
        end
    endtask

    task automatic directed(input logic [31:0] inst, input int fw, input int mw, input bit tk,
                            input int exp_len, input string name);
        int s0;
        bit h;
        s0 = q.size();
        gen_instr(inst, fw, mw, tk, -1, h);
        chk(name, 32'(q.size() - s0), 32'(exp_len));
        run_queue();
    endtask

    logic [6:0] legal_ops [8] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                                  7'b0110011, 7'b0110111, 7'b1101111, 7'b1100111};

    initial begin
        bit h;
        int sel, fw, mw;
        logic [6:0] op;
        repeat (2) @(posedge clk);

        directed(32'h00500093, 1, 0, 0, 5, "len_addi");
        directed(32'h0040A103, 0, 3, 0, 8, "len_lw");
        directed(32'h00112023, 0, 0, 0, 4, "len_sw");
        directed(32'h00000463, 0, 0, 1, 3, "len_beq_taken");
        directed(32'h00000463, 0, 0, 0, 3, "len_beq_not_taken");
        directed(32'h008000EF, 0, 0, 0, 4, "len_jal");
        directed(32'h000080E7, 0, 0, 0, 4, "len_jalr");
        directed(32'h123450B7, 0, 0, 0, 4, "len_lui");
        directed(32'h002081B3, 0, 0, 0, 4, "len_add");
        directed(32'h00500093, 15, 0, 0, 19, "len_fetch_ready_at_limit");
        directed(32'h0040A103, 0, 15, 0, 20, "len_mem_ready_at_limit");
        chk("model_instret", 32'(m_cnt), 32'd11);

        gen_instr(32'h0000007F, 0, 0, 0, -1, h);
        chk("illegal_halts", 32'(h), 32'd1);
        gen_halt(3, 1);
        run_queue();

        gen_instr(32'h00500093, TIMEOUT, 0, 0, -1, h);
        chk("len_fetch_timeout", 32'(q.size()), 32'd16);
        gen_halt(2, 1);
        run_queue();

        gen_instr(32'h00112023, 0, TIMEOUT, 0, -1, h);
        gen_halt(2, 1);
        run_queue();

        gen_instr(32'h00112023, 0, 2, 0, 5, h);
        gen_instr(32'h00500093, 0, 0, 0, -1, h);
        gen_instr(32'h00500093, 4, 0, 0, 2, h);
        gen_instr(32'h00500093, 0, 0, 0, -1, h);
        run_queue();

        for (int i = 0; i < 66; i++) gen_instr(32'h00000463, 0, 0, 1'($urandom_range(0, 1)), -1, h);
        chk("model_instret_wrap", 32'(m_cnt), 32'd3);
        run_queue();

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            fw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            op = legal_ops[$urandom_range(0, 7)];
            if (sel < 2) begin
                op = 7'($urandom_range(0, 127));
                while (cls_of(op) != C_ILL) op = 7'($urandom_range(0, 127));
            end else if (sel < 4) fw = TIMEOUT;
            else if (sel < 6) mw = TIMEOUT;
            gen_instr({25'($urandom), op}, fw, mw, 1'($urandom_range(0, 1)),
                      (sel >= 6 && sel < 9) ? $urandom_range(0, 5) : -1, h);
            if (h) gen_halt($urandom_range(1, 3), 1);
            run_queue();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
